// File: rtl/mips_top_module.sv
// Single-cycle 32-bit MIPS core: PC, instruction memory with a serial load
// path, register file, ALU, decoder and data memory. Every instruction
// retires on the rising edge that follows its fetch.
//
// There is no valid/ready handshake anywhere in this design: the load path
// is a plain write strobe (instr_WE) sampled on the clock edge, and the core
// itself has no stall or back-pressure. The core has no FSM; its only
// control state is the PC and the load pointer.

package mips_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// Instruction memory: combinational fetch, synchronous write used only by
// the serial load path. Never reset so preloaded code survives rstn.
module mips_imem #(
  parameter int IMEM_DEPTH = 256,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] I_MEM [0:IMEM_DEPTH-1];

  // Load-path write; no reset on purpose.
  always_ff @(posedge clk) begin
    if (we) begin
      I_MEM[waddr] <= wdata;
    end
  end

  assign rdata = I_MEM[raddr];

endmodule

// Register file: two combinational read ports, one synchronous write port.
// A same-cycle read of the register being written returns the old value.
module mips_regfile (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] v0
);

  logic [31:0] regs [0:31];

  // Clear everything on reset; $0 is never written so it stays zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
  assign v0  = regs[2];

endmodule

// ALU: 32-bit wrap-around arithmetic, signed set-less-than, shifts by shamt.
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);

  // Pure function of the operands; shifts operate on b (the rt operand).
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      default: y = '0;
    endcase
  end

endmodule

// Main decoder. Anything unrecognised leaves every enable low, which makes
// it a NOP that simply advances the PC.
module mips_control
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_imm,
  output logic       imm_zext,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       jump,
  output alu_op_t    alu_op
);

  // Opcode/funct decode into datapath controls, defaults first.
  always_comb begin
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    alu_op      = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (funct)
          FN_ADD: begin reg_write = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin reg_write = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin reg_write = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin reg_write = 1'b1; alu_op = ALU_OR;  end
          FN_NOR: begin reg_write = 1'b1; alu_op = ALU_NOR; end
          FN_SLT: begin reg_write = 1'b1; alu_op = ALU_SLT; end
          FN_SLL: begin reg_write = 1'b1; alu_op = ALU_SLL; end
          FN_SRL: begin reg_write = 1'b1; alu_op = ALU_SRL; end
          default: reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = ALU_ADD;
      end
      OP_SLTI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = ALU_SLT;
      end
      OP_ANDI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm_zext    = 1'b1;
        alu_op      = ALU_AND;
      end
      OP_ORI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        imm_zext    = 1'b1;
        alu_op      = ALU_OR;
      end
      OP_LW: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
        alu_op      = ALU_ADD;
      end
      OP_SW: begin
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = ALU_ADD;
      end
      OP_BEQ: branch_eq = 1'b1;
      OP_BNE: branch_ne = 1'b1;
      OP_J:   jump      = 1'b1;
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

endmodule

// Data memory: combinational read, synchronous write. Word addressed; the
// caller passes only the word-index bits so addresses wrap naturally.
module mips_dmem #(
  parameter int DMEM_DEPTH = 256,
  parameter int DAW        = $clog2(DMEM_DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [DAW-1:0] addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);

  logic [31:0] D_MEM [0:DMEM_DEPTH-1];

  // Store port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      D_MEM[addr] <= wdata;
    end
  end

  assign rdata = D_MEM[addr];

endmodule

// Top level: wires the datapath together and owns the PC and load pointer.
// Both memory depths are expected to be powers of two so that the index
// slices below wrap modulo the depth.
module mips_top_module
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_WE,
  input  logic [31:0] instr_WD,
  output logic [31:0] test_value
);

  localparam int          AW       = $clog2(IMEM_DEPTH);
  localparam int          DAW      = $clog2(DMEM_DEPTH);
  localparam logic [31:0] PC_MASK  = 32'((IMEM_DEPTH * 4) - 1);
  localparam logic [AW-1:0] LOAD_LAST = AW'(IMEM_DEPTH - 1);

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   pc_plus4;
  logic [31:0]   branch_target;
  logic [AW-1:0] load_ptr;
  logic [31:0]   instr;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] jaddr;

  logic    reg_write;
  logic    reg_dst;
  logic    alu_src_imm;
  logic    imm_zext;
  logic    mem_write;
  logic    mem_to_reg;
  logic    branch_eq;
  logic    branch_ne;
  logic    jump;
  alu_op_t alu_op;

  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_ext;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wr_reg;
  logic        take_branch;
  logic        exec_en;
  logic        imem_we;

  // Execution is frozen while the load path is active or reset is held.
  assign exec_en = rstn & ~instr_WE;
  assign imem_we = rstn & instr_WE;

  mips_imem #(.IMEM_DEPTH(IMEM_DEPTH), .AW(AW)) INSTRUCTION_MEMORY (
    .clk   (clk),
    .we    (imem_we),
    .waddr (load_ptr),
    .wdata (instr_WD),
    .raddr (pc[AW+1:2]),
    .rdata (instr)
  );

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];
  assign jaddr = instr[25:0];

  mips_control CONTROL (
    .op          (op),
    .funct       (funct),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .alu_src_imm (alu_src_imm),
    .imm_zext    (imm_zext),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .alu_op      (alu_op)
  );

  assign wr_reg  = reg_dst ? rd : rt;
  assign wb_data = mem_to_reg ? dmem_rdata : alu_result;

  mips_regfile REG_FILE (
    .clk  (clk),
    .rstn (rstn),
    .we   (reg_write & exec_en),
    .ra1  (rs),
    .ra2  (rt),
    .wa   (wr_reg),
    .wd   (wb_data),
    .rd1  (rd1),
    .rd2  (rd2),
    .v0   (test_value)
  );

  assign imm_ext = imm_zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = alu_src_imm ? imm_ext : rd2;

  mips_alu ALU (
    .op    (alu_op),
    .a     (rd1),
    .b     (alu_b),
    .shamt (shamt),
    .y     (alu_result)
  );

  mips_dmem #(.DMEM_DEPTH(DMEM_DEPTH), .DAW(DAW)) DATA_MEMORY (
    .clk   (clk),
    .we    (mem_write & exec_en),
    .addr  (alu_result[DAW+1:2]),
    .wdata (rd2),
    .rdata (dmem_rdata)
  );

  // Next-PC selection: jump, taken branch, or fall through.
  always_comb begin
    pc_plus4      = pc + 32'd4;
    branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    take_branch   = (branch_eq && (rd1 == rd2)) || (branch_ne && (rd1 != rd2));
    pc_next       = pc_plus4;
    if (jump) begin
      pc_next = {pc_plus4[31:28], jaddr, 2'b00};
    end else if (take_branch) begin
      pc_next = branch_target;
    end
  end

  // PC register: held during loading, wrapped to the instruction memory span.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc <= '0;
    end else if (!instr_WE) begin
      pc <= pc_next & PC_MASK;
    end
  end

  // Load pointer walks I_MEM one word per strobe and wraps at the end.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      load_ptr <= '0;
    end else if (instr_WE) begin
      load_ptr <= (load_ptr == LOAD_LAST) ? '0 : load_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_top_module.sv
// Directed bench for the single-cycle MIPS core. Programs are written into
// instruction memory through the instr_WE load path after a reset; results
// are read from test_value and from internal state by hierarchical name.
module tb_mips_top_module;

  logic        clk;
  logic        rstn;
  logic        instr_WE;
  logic [31:0] instr_WD;
  logic [31:0] test_value;

  int checks;
  int errors;

  logic [31:0] prog_q[$];

  mips_top_module uut (
    .clk        (clk),
    .rstn       (rstn),
    .instr_WE   (instr_WE),
    .instr_WD   (instr_WD),
    .test_value (test_value)
  );

  // Clock and initial input levels.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rstn     = 1'b0;
    instr_WE = 1'b0;
    instr_WD = '0;
  end

  localparam logic [31:0] HALT = 32'h1000FFFF;  // beq $0,$0,-1

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] addr);
    return {6'h02, addr};
  endfunction

  // Driver tasks: inputs change on the falling edge, outputs sampled there too.
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    instr_WE = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic load_prog();
    instr_WE = 1'b1;
    foreach (prog_q[i]) begin
      instr_WD = prog_q[i];
      @(negedge clk);
    end
    instr_WE = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (uut.pc !== 32'd0) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", uut.pc, 32'd0);
    end
    checks++;
    if (test_value !== 32'd0) begin
      errors++; $display("FAIL reset_tv: got %h expected %h", test_value, 32'd0);
    end
    rstn = 1'b1;
    prog_q = '{enc_i(6'h08, 5'd0, 5'd2, 16'h0005), HALT};
    load_prog();
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (test_value !== 32'd0) begin
      errors++; $display("FAIL reset_during: got %h expected %h", test_value, 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (test_value !== 32'h5) begin
      errors++; $display("FAIL first_exec_tv: got %h expected %h", test_value, 32'h5);
    end
    checks++;
    if (uut.pc !== 32'd4) begin
      errors++; $display("FAIL first_exec_pc: got %h expected %h", uut.pc, 32'd4);
    end
  endtask

  task automatic load_arith();
    prog_q = '{enc_i(6'h08, 5'd0, 5'd8, 16'd7),
               enc_i(6'h08, 5'd0, 5'd9, 16'd3),
               enc_r(5'd8, 5'd9, 5'd2, 5'd0, 6'h22),
               enc_r(5'd9, 5'd8, 5'd10, 5'd0, 6'h2A),
               HALT};
    load_prog();
  endtask

  task automatic test_arith();
    do_reset();
    load_arith();
    run(2);
    checks++;
    if (uut.REG_FILE.regs[9] !== 32'd3) begin
      errors++; $display("FAIL arith_r9: got %h expected %h", uut.REG_FILE.regs[9], 32'd3);
    end
    run(3);
    checks++;
    if (test_value !== 32'd4) begin
      errors++; $display("FAIL arith_sub: got %h expected %h", test_value, 32'd4);
    end
    checks++;
    if (uut.REG_FILE.regs[10] !== 32'd1) begin
      errors++; $display("FAIL arith_slt: got %h expected %h", uut.REG_FILE.regs[10], 32'd1);
    end
    checks++;
    if (uut.pc !== 32'd16) begin
      errors++; $display("FAIL arith_pc: got %h expected %h", uut.pc, 32'd16);
    end
  endtask

  task automatic test_mem();
    do_reset();
    prog_q = '{enc_i(6'h08, 5'd0, 5'd8, 16'h1234),
               enc_i(6'h2B, 5'd0, 5'd8, 16'h0008),
               enc_i(6'h23, 5'd0, 5'd2, 16'h0008),
               enc_i(6'h08, 5'd0, 5'd9, 16'h0055),
               enc_i(6'h2B, 5'd0, 5'd9, 16'h040C),
               enc_i(6'h23, 5'd0, 5'd3, 16'h000C),
               enc_i(6'h23, 5'd0, 5'd4, 16'h000E),
               HALT};
    load_prog();
    run(8);
    checks++;
    if (test_value !== 32'h1234) begin
      errors++; $display("FAIL mem_lw: got %h expected %h", test_value, 32'h1234);
    end
    checks++;
    if (uut.DATA_MEMORY.D_MEM[2] !== 32'h1234) begin
      errors++; $display("FAIL mem_word2: got %h expected %h", uut.DATA_MEMORY.D_MEM[2], 32'h1234);
    end
    checks++;
    if (uut.DATA_MEMORY.D_MEM[3] !== 32'h55) begin
      errors++; $display("FAIL mem_wrap: got %h expected %h", uut.DATA_MEMORY.D_MEM[3], 32'h55);
    end
    checks++;
    if (uut.REG_FILE.regs[3] !== 32'h55) begin
      errors++; $display("FAIL mem_lw_r3: got %h expected %h", uut.REG_FILE.regs[3], 32'h55);
    end
    checks++;
    if (uut.REG_FILE.regs[4] !== 32'h55) begin
      errors++; $display("FAIL mem_byteoff: got %h expected %h", uut.REG_FILE.regs[4], 32'h55);
    end
  endtask

  task automatic test_branch_jump();
    int bad;
    do_reset();
    prog_q = '{enc_i(6'h08, 5'd0, 5'd2, 16'h0001),
               enc_i(6'h04, 5'd0, 5'd0, 16'h0001),
               enc_i(6'h08, 5'd2, 5'd2, 16'h0001),
               enc_i(6'h08, 5'd2, 5'd2, 16'h0010),
               enc_j(26'd6),
               enc_i(6'h08, 5'd2, 5'd2, 16'h0100),
               HALT};
    load_prog();
    run(6);
    checks++;
    if (test_value !== 32'h11) begin
      errors++; $display("FAIL branch_tv: got %h expected %h", test_value, 32'h11);
    end
    checks++;
    if (uut.pc !== 32'd24) begin
      errors++; $display("FAIL jump_pc: got %h expected %h", uut.pc, 32'd24);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((uut.pc !== 32'd24) || (test_value !== 32'h11)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_logic();
    do_reset();
    prog_q = '{enc_i(6'h0D, 5'd0, 5'd8, 16'hF0F0),
               enc_i(6'h0C, 5'd8, 5'd9, 16'h0FF0),
               enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h27),
               enc_r(5'd0, 5'd9, 5'd11, 5'd4, 6'h00),
               enc_r(5'd0, 5'd10, 5'd12, 5'd8, 6'h02),
               enc_i(6'h0A, 5'd10, 5'd13, 16'hFFFF),
               enc_i(6'h08, 5'd0, 5'd14, 16'hFFFF),
               enc_i(6'h05, 5'd14, 5'd0, 16'h0001),
               enc_i(6'h08, 5'd0, 5'd2, 16'h0077),
               enc_r(5'd11, 5'd9, 5'd2, 5'd0, 6'h25),
               32'hFC02FFFF,
               HALT};
    load_prog();
    run(12);
    checks++;
    if (uut.REG_FILE.regs[8] !== 32'h0000F0F0) begin
      errors++; $display("FAIL ori: got %h expected %h", uut.REG_FILE.regs[8], 32'h0000F0F0);
    end
    checks++;
    if (uut.REG_FILE.regs[9] !== 32'h000000F0) begin
      errors++; $display("FAIL andi: got %h expected %h", uut.REG_FILE.regs[9], 32'h000000F0);
    end
    checks++;
    if (uut.REG_FILE.regs[10] !== 32'hFFFF0F0F) begin
      errors++; $display("FAIL nor: got %h expected %h", uut.REG_FILE.regs[10], 32'hFFFF0F0F);
    end
    checks++;
    if (uut.REG_FILE.regs[11] !== 32'h00000F00) begin
      errors++; $display("FAIL sll: got %h expected %h", uut.REG_FILE.regs[11], 32'h00000F00);
    end
    checks++;
    if (uut.REG_FILE.regs[12] !== 32'h00FFFF0F) begin
      errors++; $display("FAIL srl: got %h expected %h", uut.REG_FILE.regs[12], 32'h00FFFF0F);
    end
    checks++;
    if (uut.REG_FILE.regs[13] !== 32'd1) begin
      errors++; $display("FAIL slti: got %h expected %h", uut.REG_FILE.regs[13], 32'd1);
    end
    checks++;
    if (uut.REG_FILE.regs[14] !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL addi_neg: got %h expected %h", uut.REG_FILE.regs[14], 32'hFFFFFFFF);
    end
    checks++;
    if (test_value !== 32'h00000FF0) begin
      errors++; $display("FAIL bne_or_nop: got %h expected %h", test_value, 32'h00000FF0);
    end
    checks++;
    if (uut.pc !== 32'd44) begin
      errors++; $display("FAIL logic_pc: got %h expected %h", uut.pc, 32'd44);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    prog_q = '{enc_i(6'h08, 5'd0, 5'd2, 16'h0003),
               enc_i(6'h08, 5'd0, 5'd0, 16'h0009),
               enc_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h20),
               HALT};
    load_prog();
    run(1);
    checks++;
    if (test_value !== 32'd3) begin
      errors++; $display("FAIL zero_pre: got %h expected %h", test_value, 32'd3);
    end
    run(3);
    checks++;
    if (test_value !== 32'd0) begin
      errors++; $display("FAIL zero_reg: got %h expected %h", test_value, 32'd0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_arith();
    run(3);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (uut.pc !== 32'd0) begin
      errors++; $display("FAIL midreset_pc: got %h expected %h", uut.pc, 32'd0);
    end
    checks++;
    if (test_value !== 32'd0) begin
      errors++; $display("FAIL midreset_tv: got %h expected %h", test_value, 32'd0);
    end
    rstn = 1'b1;
    run(5);
    checks++;
    if (test_value !== 32'd4) begin
      errors++; $display("FAIL rerun_tv: got %h expected %h", test_value, 32'd4);
    end
    checks++;
    if (uut.REG_FILE.regs[10] !== 32'd1) begin
      errors++; $display("FAIL rerun_slt: got %h expected %h", uut.REG_FILE.regs[10], 32'd1);
    end
  endtask

  task automatic test_load();
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = enc_i(6'h08, 5'd0, 5'd2, 16'h0021);
    w1 = HALT;
    do_reset();
    instr_WE = 1'b1;
    instr_WD = w0;
    @(negedge clk);
    checks++;
    if (uut.pc !== 32'd0) begin
      errors++; $display("FAIL load_pc_hold0: got %h expected %h", uut.pc, 32'd0);
    end
    instr_WD = w1;
    @(negedge clk);
    instr_WE = 1'b0;
    checks++;
    if (uut.pc !== 32'd0) begin
      errors++; $display("FAIL load_pc_hold1: got %h expected %h", uut.pc, 32'd0);
    end
    checks++;
    if (uut.INSTRUCTION_MEMORY.I_MEM[0] !== w0) begin
      errors++; $display("FAIL load_w0: got %h expected %h", uut.INSTRUCTION_MEMORY.I_MEM[0], w0);
    end
    checks++;
    if (uut.INSTRUCTION_MEMORY.I_MEM[1] !== w1) begin
      errors++; $display("FAIL load_w1: got %h expected %h", uut.INSTRUCTION_MEMORY.I_MEM[1], w1);
    end
    checks++;
    if (test_value !== 32'd0) begin
      errors++; $display("FAIL load_noexec: got %h expected %h", test_value, 32'd0);
    end
    run(1);
    checks++;
    if (test_value !== 32'h21) begin
      errors++; $display("FAIL load_exec: got %h expected %h", test_value, 32'h21);
    end
  endtask

  // Test sequence and final report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_mem();
    test_branch_jump();
    test_logic();
    test_zero_reg();
    test_reset_mid();
    test_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
